pipeline_debug_unit: RTL and testbench

PIPELINE_DEBUG_UNIT -- requirements
Module: pipeline_debug_unit

---
 rtl/dbg_pkg.sv | 41 ++++
 rtl/dbg_word_serializer.sv | 65 ++++++
 rtl/pipeline_debug_unit.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_pipeline_debug_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg -- shared constants for the pipeline debug unit.
//   Host command bytes, the watchdog error byte, the o_state encoding,
//   the dump sub-phase type and the watchdog counter width.
package dbg_pkg;

  // Host command bytes received in IDLE
  localparam logic [7:0] CMD_PROG = 8'hFE;
  localparam logic [7:0] CMD_RUN  = 8'hF0;
  localparam logic [7:0] CMD_STEP = 8'hF1;
  localparam logic [7:0] CMD_DUMP = 8'hF2;

  // Byte sent ahead of the dump when a RUN times out
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // RUN timeout counter width (2^WD_W cycles)
  localparam int WD_W = 20;

  // State codes, visible on o_state
  localparam logic [7:0] ST_IDLE     = 8'h00;
  localparam logic [7:0] ST_PROG_SZ  = 8'h01;
  localparam logic [7:0] ST_LOAD     = 8'h02;
  localparam logic [7:0] ST_RUN      = 8'h03;
  localparam logic [7:0] ST_STEP     = 8'h04;
  localparam logic [7:0] ST_DUMP_PC  = 8'h05;
  localparam logic [7:0] ST_DUMP_REG = 8'h06;
  localparam logic [7:0] ST_DUMP_MEM = 8'h07;
  localparam logic [7:0] ST_DUMP_ERR = 8'h08;

  // Per-word dump sequence: present address, sample word, send bytes
  typedef enum logic [1:0] {
    PH_ADDR = 2'd0,
    PH_LOAD = 2'd1,
    PH_SEND = 2'd2
  } dump_phase_e;

  // States in which the unit consumes bytes from the RX FIFO
  function automatic logic rx_window(input logic [7:0] st);
    return (st == ST_IDLE) || (st == ST_PROG_SZ) || (st == ST_LOAD);
  endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// dbg_word_serializer -- sends the low i_nbytes bytes of a word, LSB first,
// into a TX FIFO.
//   i_clk, i_reset     : clock, asynchronous active-low reset
//   i_start, i_word,
//   i_nbytes           : load a new word (accepted only while idle)
//   i_tx_full          : TX FIFO full; the current byte waits while high
//   o_wr_uart,o_tx_data: one-cycle write strobe and the byte being written
//   o_done             : high in the cycle the final byte is written
module dbg_word_serializer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_word,
  input  logic [7:0]   i_nbytes,
  input  logic         i_tx_full,
  output logic         o_wr_uart,
  output logic [7:0]   o_tx_data,
  output logic         o_done
);

  logic [W-1:0] shift_q, shift_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         fire;

  // Shift out one byte per accepted write; load a new word when idle
  always_comb begin
    fire    = busy_q & ~i_tx_full;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (fire) begin
      shift_d = shift_q >> 32'd8;
      cnt_d   = cnt_q - 8'd1;
      busy_d  = (cnt_q != 8'd1);
    end else if (i_start && !busy_q) begin
      shift_d = i_word;
      cnt_d   = i_nbytes;
      busy_d  = (i_nbytes != 8'd0);
    end else begin
      busy_d  = busy_q;
    end
  end

  // Serializer state registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= {W{1'b0}};
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The strobe is qualified by the live full flag so a full FIFO is never written
  assign o_wr_uart = fire;
  assign o_tx_data = shift_q[7:0];
  assign o_done    = fire & (cnt_q == 8'd1);

endmodule

// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit -- UART-driven debug controller for a pipelined core.
//   Loads a program into instruction memory, runs or single-steps the core,
//   then dumps PC, register file and data memory back over the UART.
//   i_clk, i_reset              : clock, asynchronous active-low reset
//   i_rx_empty, i_rx_data,
//   o_rd_uart                   : RX FIFO (first-word-fall-through) pop side
//   i_tx_full, o_wr_uart,
//   o_tx_data                   : TX FIFO push side
//   i_register_data,
//   i_memory_data               : dump read data, valid one cycle after o_addr
//   i_pc, i_halt                : core PC and halt flag
//   o_instruction, o_mem_w      : instruction memory write data / strobe
//   o_enable                    : core clock enable
//   o_addr                      : load word index or dump read address
//   o_prog_sz, o_state          : program length in words, FSM state code
// Build option: define DBG_WATCHDOG_EN to abort a RUN after 2^WD_W cycles
// without halt, sending ERR_BYTE before the dump.
module pipeline_debug_unit
  import dbg_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int DATA_SZ = 32,
  parameter int PC_SZ   = 32,
  parameter int NREGS   = 32,
  parameter int NMEM    = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [7:0]         i_rx_data,
  output logic               o_rd_uart,
  input  logic               i_tx_full,
  output logic               o_wr_uart,
  output logic [7:0]         o_tx_data,
  input  logic [DATA_SZ-1:0] i_register_data,
  input  logic [DATA_SZ-1:0] i_memory_data,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic               i_halt,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_mem_w,
  output logic               o_enable,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [7:0]         o_prog_sz,
  output logic [7:0]         o_state
);

  localparam int SER_W  = (PC_SZ > DATA_SZ) ? PC_SZ : DATA_SZ;
  localparam int INST_B = INST_SZ / 8;

  logic [7:0]         state_q, state_d;
  dump_phase_e        phase_q, phase_d;
  logic [INST_SZ-1:0] inst_q, inst_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         word_cnt_q, word_cnt_d;
  logic [7:0]         prog_sz_q, prog_sz_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               mem_w_q, mem_w_d;
  logic               accept_q, accept_d;

  logic               rd_s;
  logic               dump_last;
  logic               ser_start;
  logic [SER_W-1:0]   ser_word;
  logic [7:0]         ser_nbytes;
  logic               ser_done;
`ifdef DBG_WATCHDOG_EN
  logic [WD_W-1:0]    wd_q, wd_d;
`endif

  // accept_q is registered so the pop strobe is low throughout reset
  assign rd_s = accept_q & ~i_rx_empty;

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    inst_d     = inst_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    prog_sz_d  = prog_sz_q;
    mem_w_d    = 1'b0;
    ser_start  = 1'b0;
    ser_word   = {SER_W{1'b0}};
    ser_nbytes = 8'd0;
    dump_last  = 1'b0;
`ifdef DBG_WATCHDOG_EN
    wd_d       = {WD_W{1'b0}};
`endif

    // The load word index advances the cycle after its write pulse
    if (mem_w_q) begin
      addr_d = addr_q + ADDR_W'(1'b1);
    end else begin
      addr_d = addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_s) begin
          case (i_rx_data)
            CMD_PROG: state_d = ST_PROG_SZ;
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: begin
              state_d = ST_DUMP_PC;
              phase_d = PH_LOAD;
            end
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PROG_SZ: begin
        if (rd_s) begin
          prog_sz_d  = i_rx_data;
          addr_d     = {ADDR_W{1'b0}};
          byte_cnt_d = 8'd0;
          word_cnt_d = 8'd0;
          state_d    = (i_rx_data == 8'd0) ? ST_IDLE : ST_LOAD;
        end else begin
          state_d = ST_PROG_SZ;
        end
      end

      ST_LOAD: begin
        if (rd_s) begin
          // Bytes enter at the top so the first one ends up in bits [7:0]
          inst_d = (inst_q >> 32'd8) | (INST_SZ'(i_rx_data) << (INST_SZ - 8));
          if (byte_cnt_q == 8'(INST_B - 1)) begin
            byte_cnt_d = 8'd0;
            mem_w_d    = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
            state_d    = (word_cnt_q == prog_sz_q - 8'd1) ? ST_IDLE : ST_LOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_DUMP_PC;
          phase_d = PH_LOAD;
`ifdef DBG_WATCHDOG_EN
        end else if (wd_q == {WD_W{1'b1}}) begin
          state_d = ST_DUMP_ERR;
          phase_d = PH_LOAD;
        end else begin
          wd_d = wd_q + WD_W'(1'b1);
        end
`else
        end else begin
          state_d = ST_RUN;
        end
`endif
      end

      ST_STEP: begin
        state_d = ST_DUMP_PC;
        phase_d = PH_LOAD;
      end

`ifdef DBG_WATCHDOG_EN
      ST_DUMP_ERR: begin
        ser_word   = SER_W'(ERR_BYTE);
        ser_nbytes = 8'd1;
        case (phase_q)
          PH_LOAD: begin
            ser_start = 1'b1;
            phase_d   = PH_SEND;
          end
          PH_SEND: begin
            if (ser_done) begin
              state_d = ST_DUMP_PC;
              phase_d = PH_LOAD;
            end else begin
              phase_d = PH_SEND;
            end
          end
          default: phase_d = PH_LOAD;
        endcase
      end
`endif

      ST_DUMP_PC: begin
        ser_word   = SER_W'(i_pc);
        ser_nbytes = 8'(PC_SZ / 8);
        case (phase_q)
          PH_LOAD: begin
            ser_start = 1'b1;
            phase_d   = PH_SEND;
          end
          PH_SEND: begin
            if (ser_done) begin
              state_d = ST_DUMP_REG;
              addr_d  = {ADDR_W{1'b0}};
              phase_d = PH_ADDR;
            end else begin
              phase_d = PH_SEND;
            end
          end
          default: phase_d = PH_LOAD;
        endcase
      end

      ST_DUMP_REG, ST_DUMP_MEM: begin
        if (state_q == ST_DUMP_REG) begin
          ser_word  = SER_W'(i_register_data);
          dump_last = (addr_q == ADDR_W'(NREGS - 1));
        end else begin
          ser_word  = SER_W'(i_memory_data);
          dump_last = (addr_q == ADDR_W'(NMEM - 1));
        end
        ser_nbytes = 8'(DATA_SZ / 8);
        // PH_ADDR gives the synchronous read port a cycle before sampling
        case (phase_q)
          PH_ADDR: phase_d = PH_LOAD;
          PH_LOAD: begin
            ser_start = 1'b1;
            phase_d   = PH_SEND;
          end
          PH_SEND: begin
            if (ser_done) begin
              phase_d = PH_ADDR;
              if (dump_last) begin
                addr_d  = {ADDR_W{1'b0}};
                state_d = (state_q == ST_DUMP_REG) ? ST_DUMP_MEM : ST_IDLE;
              end else begin
                addr_d = addr_q + ADDR_W'(1'b1);
              end
            end else begin
              phase_d = PH_SEND;
            end
          end
          default: phase_d = PH_ADDR;
        endcase
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_ADDR;
      end
    endcase

    accept_d = rx_window(state_d);
  end

  // Control and datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ADDR;
      inst_q     <= {INST_SZ{1'b0}};
      byte_cnt_q <= 8'd0;
      word_cnt_q <= 8'd0;
      prog_sz_q  <= 8'd0;
      addr_q     <= {ADDR_W{1'b0}};
      mem_w_q    <= 1'b0;
      accept_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      inst_q     <= inst_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      prog_sz_q  <= prog_sz_d;
      addr_q     <= addr_d;
      mem_w_q    <= mem_w_d;
      accept_q   <= accept_d;
    end
  end

`ifdef DBG_WATCHDOG_EN
  // RUN timeout counter, cleared whenever the unit is outside RUN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wd_q <= {WD_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  dbg_word_serializer #(.W(SER_W)) u_ser (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (ser_start),
    .i_word    (ser_word),
    .i_nbytes  (ser_nbytes),
    .i_tx_full (i_tx_full),
    .o_wr_uart (o_wr_uart),
    .o_tx_data (o_tx_data),
    .o_done    (ser_done)
  );

  // Enable drops in the same cycle halt is seen; STEP lasts exactly one cycle
  assign o_enable      = ((state_q == ST_RUN) & ~i_halt) | (state_q == ST_STEP);
  assign o_rd_uart     = rd_s;
  assign o_instruction = inst_q;
  assign o_mem_w       = mem_w_q;
  assign o_addr        = addr_q;
  assign o_prog_sz     = prog_sz_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Scoreboard bench for pipeline_debug_unit (default parameters).
module tb_pipeline_debug_unit;

  localparam int NW = 260;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_full = 1'b0;
  logic [31:0] reg_data = 32'h0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        halt = 1'b0;
  logic        o_rd_uart, o_wr_uart, o_mem_w, o_enable;
  logic [7:0]  o_tx_data, o_prog_sz, o_state;
  logic [31:0] o_instruction;
  logic [4:0]  o_addr;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int rd_cnt = 0;

  logic [7:0]  tx_act_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [36:0] w_act_q[$];
  logic [36:0] w_exp_q[$];

  always #5 clk = ~clk;

  pipeline_debug_unit dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rd_uart(o_rd_uart),
    .i_tx_full(tx_full), .o_wr_uart(o_wr_uart), .o_tx_data(o_tx_data),
    .i_register_data(reg_data), .i_memory_data(mem_data),
    .i_pc(pc), .i_halt(halt),
    .o_instruction(o_instruction), .o_mem_w(o_mem_w), .o_enable(o_enable),
    .o_addr(o_addr), .o_prog_sz(o_prog_sz), .o_state(o_state)
  );

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return {8'hA5, 3'b000, a, 8'h5A, 3'b111, ~a};
  endfunction

  function automatic logic [31:0] mem_val(input logic [4:0] a);
    return {8'hC3, 3'b000, a, 8'h3C, 3'b010, a};
  endfunction

  // Register file and data memory with one cycle of read latency
  always @(posedge clk) begin
    reg_data <= reg_val(o_addr);
    mem_data <= mem_val(o_addr);
  end

  // Output recorders, sampled on the falling edge
  always @(negedge clk) begin
    if (o_wr_uart) tx_act_q.push_back(o_tx_data);
    if (o_mem_w) w_act_q.push_back({o_addr, o_instruction});
    if (o_enable) en_cnt <= en_cnt + 1;
    if (o_rd_uart) rd_cnt <= rd_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    bit popped;
    popped = 1'b0;
    @(posedge clk); #1;
    rx_data = b;
    rx_empty = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_rd_uart) begin
        popped = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    rx_empty = 1'b1;
    checks++;
    if (!popped) begin
      failures++;
      $display("FAIL rx_pop byte=%h observed no o_rd_uart required one pop", b);
    end
  endtask

  task automatic push_dump(input logic [31:0] pcv);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) tx_exp_q.push_back(pcv[8*b +: 8]);
    for (int r = 0; r < 32; r++) begin
      w = reg_val(5'(r));
      for (int b = 0; b < 4; b++) tx_exp_q.push_back(w[8*b +: 8]);
    end
    for (int m = 0; m < 32; m++) begin
      w = mem_val(5'(m));
      for (int b = 0; b < 4; b++) tx_exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (tx_act_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_empty = 1'b0;
    rx_data = 8'hFE;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL reset_state observed %h required 00", o_state); end
    checks++; if (o_rd_uart !== 1'b0) begin failures++; $display("FAIL reset_rd observed %b required 0", o_rd_uart); end
    checks++; if (o_wr_uart !== 1'b0) begin failures++; $display("FAIL reset_wr observed %b required 0", o_wr_uart); end
    checks++; if (o_mem_w !== 1'b0) begin failures++; $display("FAIL reset_mem_w observed %b required 0", o_mem_w); end
    checks++; if (o_enable !== 1'b0) begin failures++; $display("FAIL reset_enable observed %b required 0", o_enable); end
    checks++; if (o_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr observed %h required 0", o_instruction); end
    checks++; if (o_addr !== 5'd0) begin failures++; $display("FAIL reset_addr observed %0d required 0", o_addr); end
    checks++; if (o_prog_sz !== 8'd0) begin failures++; $display("FAIL reset_prog_sz observed %0d required 0", o_prog_sz); end
    checks++; if (o_tx_data !== 8'd0) begin failures++; $display("FAIL reset_tx_data observed %h required 0", o_tx_data); end
    rx_empty = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_load();
    logic [36:0] got, exp;
    logic [7:0] bytes [10];
    bytes = '{8'hFE, 8'h02, 8'h02, 8'h20, 8'h02, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h00};
    w_act_q.delete();
    w_exp_q.push_back({5'd0, 32'h00022002});
    w_exp_q.push_back({5'd1, 32'h0000003F});
    foreach (bytes[i]) send_byte(bytes[i]);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (w_act_q.size() != 2) begin failures++; $display("FAIL load_count observed %0d required 2", w_act_q.size()); end
    while (w_exp_q.size() > 0) begin
      exp = w_exp_q.pop_front();
      got = (w_act_q.size() > 0) ? w_act_q.pop_front() : 37'h0;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL load_write observed addr=%0d instr=%h required addr=%0d instr=%h", got[36:32], got[31:0], exp[36:32], exp[31:0]); end
    end
    checks++; if (o_prog_sz !== 8'd2) begin failures++; $display("FAIL load_prog_sz observed %0d required 2", o_prog_sz); end
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL load_end_state observed %h required 00", o_state); end
  endtask

  task automatic test_empty_prog();
    int rd_base;
    w_act_q.delete();
    send_byte(8'hFE);
    send_byte(8'h00);
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL empty_prog_state observed %h required 00", o_state); end
    rd_base = rd_cnt;
    send_byte(8'h55);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rd_cnt - rd_base != 1) begin failures++; $display("FAIL empty_prog_discard_pops observed %0d required 1", rd_cnt - rd_base); end
    checks++; if (w_act_q.size() != 0) begin failures++; $display("FAIL empty_prog_writes observed %0d required 0", w_act_q.size()); end
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL empty_prog_idle observed %h required 00", o_state); end
    checks++; if (o_prog_sz !== 8'd0) begin failures++; $display("FAIL empty_prog_sz observed %0d required 0", o_prog_sz); end
  endtask

  task automatic test_run();
    int en_base, rd_base, pos;
    bit ok;
    logic [7:0] exp, got;
    tx_act_q.delete();
    pc = 32'hDEADBEEF;
    push_dump(pc);
    en_base = en_cnt;
    send_byte(8'hF0);
    rd_base = rd_cnt;
    rx_data = 8'h12;
    rx_empty = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (en_cnt - en_base >= 50) begin
        ok = 1'b1;
        break;
      end
    end
    halt = 1'b1;
    rx_empty = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL run_enable_timeout observed %0d required 50", en_cnt - en_base); end
    wait_tx(NW, ok);
    halt = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL run_dump_timeout observed %0d bytes required %0d", tx_act_q.size(), NW); end
    checks++; if (en_cnt - en_base != 50) begin failures++; $display("FAIL run_enable_cycles observed %0d required 50", en_cnt - en_base); end
    checks++; if (rd_cnt != rd_base) begin failures++; $display("FAIL run_rx_popped observed %0d required 0", rd_cnt - rd_base); end
    checks++; if (tx_act_q.size() != NW) begin failures++; $display("FAIL run_dump_len observed %0d required %0d", tx_act_q.size(), NW); end
    pos = 0;
    while (tx_exp_q.size() > 0) begin
      exp = tx_exp_q.pop_front();
      got = (tx_act_q.size() > 0) ? tx_act_q.pop_front() : 8'h00;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL run_byte[%0d] observed %h required %h", pos, got, exp); end
      pos++;
    end
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL run_end_state observed %h required 00", o_state); end
  endtask

  task automatic test_halt_pre();
    int en_base, pos;
    bit ok;
    logic [7:0] exp, got;
    tx_act_q.delete();
    pc = 32'h00000200;
    push_dump(pc);
    halt = 1'b1;
    en_base = en_cnt;
    send_byte(8'hF0);
    wait_tx(NW, ok);
    halt = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL halt_pre_timeout observed %0d bytes required %0d", tx_act_q.size(), NW); end
    checks++; if (en_cnt != en_base) begin failures++; $display("FAIL halt_pre_enable observed %0d required 0", en_cnt - en_base); end
    checks++; if (tx_act_q.size() != NW) begin failures++; $display("FAIL halt_pre_len observed %0d required %0d", tx_act_q.size(), NW); end
    pos = 0;
    while (tx_exp_q.size() > 0) begin
      exp = tx_exp_q.pop_front();
      got = (tx_act_q.size() > 0) ? tx_act_q.pop_front() : 8'h00;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL halt_pre_byte[%0d] observed %h required %h", pos, got, exp); end
      pos++;
    end
  endtask

  task automatic test_step();
    int en_base, pos;
    bit ok;
    logic [7:0] exp, got;
    tx_act_q.delete();
    pc = 32'h00000104;
    push_dump(pc);
    en_base = en_cnt;
    send_byte(8'hF1);
    wait_tx(NW, ok);
    checks++; if (!ok) begin failures++; $display("FAIL step_timeout observed %0d bytes required %0d", tx_act_q.size(), NW); end
    checks++; if (en_cnt - en_base != 1) begin failures++; $display("FAIL step_enable_cycles observed %0d required 1", en_cnt - en_base); end
    checks++; if (tx_act_q.size() != NW) begin failures++; $display("FAIL step_len observed %0d required %0d", tx_act_q.size(), NW); end
    pos = 0;
    while (tx_exp_q.size() > 0) begin
      exp = tx_exp_q.pop_front();
      got = (tx_act_q.size() > 0) ? tx_act_q.pop_front() : 8'h00;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL step_byte[%0d] observed %h required %h", pos, got, exp); end
      pos++;
    end
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL step_end_state observed %h required 00", o_state); end
  endtask

  task automatic test_stall();
    int sz, pos;
    bit ok;
    logic [7:0] exp, got;
    tx_act_q.delete();
    pc = 32'hCAFEF00D;
    push_dump(pc);
    send_byte(8'hF2);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (tx_act_q.size() >= 37) begin
        ok = 1'b1;
        break;
      end
    end
    tx_full = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL stall_start_timeout observed %0d bytes required 37", tx_act_q.size()); end
    sz = tx_act_q.size();
    repeat (100) @(posedge clk);
    #1;
    checks++; if (tx_act_q.size() != sz) begin failures++; $display("FAIL stall_writes_while_full observed %0d required 0", tx_act_q.size() - sz); end
    tx_full = 1'b0;
    wait_tx(NW, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout observed %0d bytes required %0d", tx_act_q.size(), NW); end
    checks++; if (tx_act_q.size() != NW) begin failures++; $display("FAIL stall_len observed %0d required %0d", tx_act_q.size(), NW); end
    pos = 0;
    while (tx_exp_q.size() > 0) begin
      exp = tx_exp_q.pop_front();
      got = (tx_act_q.size() > 0) ? tx_act_q.pop_front() : 8'h00;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL stall_byte[%0d] observed %h required %h", pos, got, exp); end
      pos++;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [36:0] got, exp;
    w_act_q.delete();
    send_byte(8'hFE);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    checks++; if (o_state !== 8'h02) begin failures++; $display("FAIL midload_state observed %h required 02", o_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_state !== 8'h00) begin failures++; $display("FAIL midload_async_reset observed %h required 00", o_state); end
    checks++; if (o_prog_sz !== 8'd0) begin failures++; $display("FAIL midload_reset_prog_sz observed %0d required 0", o_prog_sz); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w_exp_q.push_back({5'd0, 32'h44332211});
    send_byte(8'hFE);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (w_act_q.size() != 1) begin failures++; $display("FAIL midload_write_count observed %0d required 1", w_act_q.size()); end
    exp = w_exp_q.pop_front();
    got = (w_act_q.size() > 0) ? w_act_q.pop_front() : 37'h0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midload_write observed addr=%0d instr=%h required addr=%0d instr=%h", got[36:32], got[31:0], exp[36:32], exp[31:0]); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_empty_prog();
    test_run();
    test_halt_pre();
    test_step();
    test_stall();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
